stream_arb_2x1: RTL

Two-input round-robin packet arbiter that sits directly upstream of mux_2x1 in the datapath. It decides which source owns the shared output, drives the select for mux_2x1, and forwards one beat per cycle through a single registered output stage. Grant is locked for the duration of a multi-beat packet, framed by a last flag, so packets from the two sources never interleave.

---
 rtl/stream_arb_2x1.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/stream_arb_2x1.sv
// -----------------------------------------------------------------------------
// stream_arb_2x1
// Two-input round-robin packet arbiter feeding a single registered output
// stage. It sits upstream of mux_2x1 and drives that mux's select.
// Once a source starts a multi-beat packet, that source keeps the grant
// until its beat flagged with last is accepted, so packets never interleave.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   a_valid/a_ready/a_data/a_last - source A beat stream
//   b_valid/b_ready/b_data/b_last - source B beat stream
//   sel                   - source of the beat held in the output register
//                           (0 = A, 1 = B, same as mux_2x1 sel)
//   out_valid/out_ready/out_data/out_last - registered output beat stream
// -----------------------------------------------------------------------------
module stream_arb_2x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t            state_r;
    logic              prio_r;        // 0 = A wins a tie in IDLE, 1 = B
    logic              out_valid_r;
    logic [WIDTH-1:0]  out_data_r;
    logic              out_last_r;
    logic              sel_r;

    logic              pipe_ready_s;
    logic              grant_a_s;
    logic              grant_b_s;
    logic              acc_a_s;
    logic              acc_b_s;

    // The output register can take a new beat when empty or being drained.
    always_comb begin
        pipe_ready_s = !out_valid_r || out_ready;
    end

    // Grant selection: open round-robin in IDLE, exclusive while locked.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (a_valid && b_valid) begin
                    grant_a_s = !prio_r;
                    grant_b_s = prio_r;
                end else begin
                    grant_a_s = a_valid;
                    grant_b_s = b_valid;
                end
            end
            // The locked source keeps the grant even through its own bubbles.
            LOCK_A: begin
                grant_a_s = 1'b1;
                grant_b_s = 1'b0;
            end
            LOCK_B: begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b1;
            end
            default: begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        endcase
    end

    // Readies and accepted-beat strobes.
    always_comb begin
        a_ready = grant_a_s && pipe_ready_s;
        b_ready = grant_b_s && pipe_ready_s;
        acc_a_s = a_valid && a_ready;
        acc_b_s = b_valid && b_ready;
    end

    // Output register, packet lock state and round-robin priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            sel_r       <= 1'b0;
            state_r     <= IDLE;
            prio_r      <= 1'b0;
        end else begin
            if (pipe_ready_s) begin
                if (acc_a_s) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= a_data;
                    out_last_r  <= a_last;
                    sel_r       <= 1'b0;
                end else if (acc_b_s) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= b_data;
                    out_last_r  <= b_last;
                    sel_r       <= 1'b1;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end
            case (state_r)
                IDLE: begin
                    if (acc_a_s) begin
                        if (a_last) begin
                            prio_r <= 1'b1;
                        end else begin
                            state_r <= LOCK_A;
                        end
                    end else if (acc_b_s) begin
                        if (b_last) begin
                            prio_r <= 1'b0;
                        end else begin
                            state_r <= LOCK_B;
                        end
                    end
                end
                LOCK_A: begin
                    if (acc_a_s && a_last) begin
                        state_r <= IDLE;
                        prio_r  <= 1'b1;
                    end
                end
                LOCK_B: begin
                    if (acc_b_s && b_last) begin
                        state_r <= IDLE;
                        prio_r  <= 1'b0;
                    end
                end
                // Unreachable encoding: fall back to a safe idle state.
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign sel       = sel_r;

endmodule
